rob_buffer: RTL

Parametrised reorder buffer for the Tomasulo core. It replaces the fixed 8x3 ROB array and the head_p/tail_p registers with a self-contained circular buffer. The buffer allocates entries in program order at issue, captures results from the common data bus (CDB), retires completed entries in order to the register bank, and flushes all younger work when a mispredicted branch retires.

---
 rtl/rob_buffer.sv | 113 +++++++++++
 1 files changed

// File: rtl/rob_buffer.sv
// Circular reorder buffer: in-order allocation at issue, out-of-order result capture
// from the CDB, in-order retirement, and a full flush when a mispredicted branch retires.
module rob_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int FUNC_W = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [FUNC_W-1:0] alloc_func,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispredict,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              lookup_done,
  output logic [DATA_W-1:0] lookup_data,
  output logic              commit_valid,
  output logic              commit_we,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              commit_flush,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0]    FULL_CNT    = (TAG_W+1)'(DEPTH);
  localparam logic [FUNC_W-1:0] FUNC_STORE  = FUNC_W'(5);
  localparam logic [FUNC_W-1:0] FUNC_BEQ    = FUNC_W'(6);
  localparam logic [FUNC_W-1:0] FUNC_BNEQ   = FUNC_W'(7);

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  done;
  logic [DEPTH-1:0]  mispred;
  logic [FUNC_W-1:0] func_q  [DEPTH];
  logic [REG_W-1:0]  rd_q    [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;

  logic              head_is_branch;
  logic              head_is_store;
  logic              do_alloc;

  assign head_is_branch = (func_q[head] == FUNC_BEQ) || (func_q[head] == FUNC_BNEQ);
  assign head_is_store  = (func_q[head] == FUNC_STORE);

  assign commit_valid = !rst && busy[head] && done[head];
  assign commit_we    = commit_valid && !head_is_branch && !head_is_store;
  assign commit_flush = commit_valid && mispred[head] && head_is_branch;
  assign commit_rd    = commit_valid ? rd_q[head]    : '0;
  assign commit_data  = commit_valid ? value_q[head] : '0;
  assign commit_tag   = commit_valid ? head          : '0;

  // Full/empty come from count, so head==tail is never ambiguous.
  assign alloc_ready = !rst && (count != FULL_CNT) && !commit_flush;
  assign alloc_tag   = tail;
  assign do_alloc    = alloc_valid && alloc_ready;

  always_comb begin
    lookup_done = 1'b0;
    lookup_data = '0;
    if (busy[lookup_tag]) begin
      if (cdb_valid && (cdb_tag == lookup_tag)) begin
        lookup_done = 1'b1;
        lookup_data = cdb_data;
      end else if (done[lookup_tag]) begin
        lookup_done = 1'b1;
        lookup_data = value_q[lookup_tag];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst || commit_flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      busy    <= '0;
      done    <= '0;
      mispred <= '0;
    end else begin
      if (cdb_valid && busy[cdb_tag]) begin
        done[cdb_tag]    <= 1'b1;
        mispred[cdb_tag] <= cdb_mispredict;
        value_q[cdb_tag] <= cdb_data;
      end
      // Retire after the CDB update so the head slot is cleared even if rewritten this cycle.
      if (commit_valid) begin
        busy[head]    <= 1'b0;
        done[head]    <= 1'b0;
        mispred[head] <= 1'b0;
        head          <= head + TAG_W'(1);
      end
      if (do_alloc) begin
        busy[tail]    <= 1'b1;
        done[tail]    <= 1'b0;
        mispred[tail] <= 1'b0;
        func_q[tail]  <= alloc_func;
        rd_q[tail]    <= alloc_rd;
        tail          <= tail + TAG_W'(1);
      end
      count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(commit_valid);
    end
  end

endmodule
